// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the sobel pipeline. Takes a raster pixel stream and keeps the
// previous two rows in line buffers and the latest three columns in a 3x3 shift window.
// It issues one window per interior pixel and tracks the frame position.
// Frames start on i_start, report busy/done, and can be aborted at any time.
//
// Handshake: a pixel transfers on a rising edge where i_pix_valid && o_pix_ready.
// o_pix_ready depends only on the registered state and never on i_pix_valid.
// The window output has no ready: o_win_valid is a one-cycle strobe, and o_win_data
// keeps its value until the next strobe.
module sobel_window_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_pix_valid,
    input  logic [DW-1:0]   i_pix_data,
    output logic            o_pix_ready,
    output logic            o_win_valid,
    output logic [9*DW-1:0] o_win_data,
    output logic            o_busy,
    output logic            o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   row_q, row_d;
    logic [9*DW-1:0] win_q, win_d;
    logic [9*DW-1:0] out_q, out_d;
    logic            vld_q, vld_d;

    // LB0 holds the row above the current one, and LB1 holds the row above that.
    logic [DW-1:0] lb0 [IMG_W];
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb0_rd, lb1_rd;

    logic accept;
    logic last_pix;
    logic issue;

    assign accept   = i_pix_valid && (state_q == ST_RUN);
    assign last_pix = accept && (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign issue    = accept && (row_q >= TWO) && (col_q >= TWO);
    assign lb0_rd   = lb0[col_q];
    assign lb1_rd   = lb1[col_q];

    // Frame sequencing. Abort wins over completion in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start && !i_abort) state_d = ST_RUN;
            ST_RUN: begin
                if (i_abort)       state_d = ST_IDLE;
                else if (last_pix) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster position. The counters are held at zero outside a frame, so each new frame
    // starts at (0,0).
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (i_abort || last_pix || state_q == ST_IDLE) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // The window shifts left by one column on every accept. The new right column comes
    // from LB1 (top), LB0 (middle) and the incoming pixel (bottom). The output copy is
    // loaded only for interior pixels, so it holds its value between strobes.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[(3*r+0)*DW +: DW] = win_q[(3*r+1)*DW +: DW];
                win_d[(3*r+1)*DW +: DW] = win_q[(3*r+2)*DW +: DW];
            end
            win_d[2*DW +: DW] = lb1_rd;
            win_d[5*DW +: DW] = lb0_rd;
            win_d[8*DW +: DW] = i_pix_data;
        end
        vld_d = issue;
        out_d = issue ? win_d : out_q;
    end

    // Control and window state registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    // Line buffer update. The old LB0 entry moves down into LB1 before the new pixel
    // overwrites it. The buffers have no reset because their contents are never used
    // before they are rewritten in the current frame.
    always_ff @(posedge CLK) begin
        if (accept) begin
            lb1[col_q] <= lb0_rd;
            lb0[col_q] <= i_pix_data;
        end
    end

    assign o_pix_ready = (state_q == ST_RUN);
    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign o_done      = (state_q == ST_DONE);
    assign o_win_valid = vld_q;
    assign o_win_data  = out_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x4 frame in which each pixel value is 4*row + col.
module tb_sobel_window_ctrl;

  localparam int DW = 8;
  localparam int W  = 9 * DW;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic         i_pix_valid = 1'b0;
  logic [DW-1:0] i_pix_data = '0;
  logic         o_pix_ready;
  logic         o_win_valid;
  logic [W-1:0] o_win_data;
  logic         o_busy;
  logic         o_done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int win_cnt = 0;
  logic [W-1:0] exp_q[$];

  sobel_window_ctrl #(.DW(DW), .IMG_W(4), .IMG_H(4), .CW(10)) dut (
    .CLK(CLK), .RST(RST), .i_start(i_start), .i_abort(i_abort),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .o_win_valid(o_win_valid), .o_win_data(o_win_data), .o_busy(o_busy), .o_done(o_done)
  );

  // clock
  always #5 CLK = ~CLK;

  // A window whose top-left pixel has value b holds b + {0,1,2,4,5,6,8,9,10}.
  function automatic logic [W-1:0] win_for(input int b);
    int off[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(b + off[k]);
    return w;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (RST && o_done) done_cnt++;
    if (RST && o_win_valid) begin
      win_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL win_unexpected got=%h expected=none", o_win_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (o_win_data !== e) begin
          n_err++;
          $display("FAIL win_data got=%h expected=%h", o_win_data, e);
        end
      end
    end
  end

  task automatic do_start();
    i_start = 1'b1;
    @(negedge CLK);
    i_start = 1'b0;
    check("start_ready", W'(o_pix_ready), W'(1));
    check("start_busy", W'(o_busy), W'(1));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_pix_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!o_pix_ready) check("ready_timeout", W'(o_pix_ready), W'(1));
  endtask

  // Sends one frame. npix limits how many pixels are sent (used by the reset test),
  // abort_at/start_at give the pixel index that carries i_abort/i_start (-1 for none).
  task automatic send_frame(input int gap_max, input int abort_at, input int start_at,
                            input int npix);
    int d0, w0;
    d0 = done_cnt;
    w0 = win_cnt;
    do_start();
    for (int p = 0; p < npix; p++) begin
      repeat ($urandom_range(0, gap_max)) begin
        i_pix_valid = 1'b0;
        @(negedge CLK);
      end
      wait_ready();
      i_pix_valid = 1'b1;
      i_pix_data  = DW'(p);
      i_abort     = (p == abort_at);
      i_start     = (p == start_at);
      if (p / 4 >= 2 && p % 4 >= 2) exp_q.push_back(win_for((p / 4 - 2) * 4 + (p % 4 - 2)));
      @(negedge CLK);
      i_abort = 1'b0;
      i_start = 1'b0;
      if (p == abort_at) begin
        i_pix_valid = 1'b0;
        check("abort_busy", W'(o_busy), W'(0));
        check("abort_ready", W'(o_pix_ready), W'(0));
        check("abort_done", W'(o_done), W'(0));
        repeat (3) @(negedge CLK);
        check("abort_no_done", W'(done_cnt), W'(d0));
        return;
      end
    end
    i_pix_valid = 1'b0;
    if (npix < 16) return;
    check("done_pulse", W'(o_done), W'(1));
    check("done_busy", W'(o_busy), W'(1));
    @(negedge CLK);
    check("done_clear", W'(o_done), W'(0));
    check("idle_busy", W'(o_busy), W'(0));
    check("idle_ready", W'(o_pix_ready), W'(0));
    @(negedge CLK);
    check("frame_done_cnt", W'(done_cnt - d0), W'(1));
    check("frame_win_cnt", W'(win_cnt - w0), W'(4));
    check("queue_empty", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, W'(o_pix_ready), W'(0));
    check({tag, "_wvalid"}, W'(o_win_valid), W'(0));
    check({tag, "_wdata"}, o_win_data, W'(0));
    check({tag, "_busy"}, W'(o_busy), W'(0));
    check({tag, "_done"}, W'(o_done), W'(0));
  endtask

  // stimulus
  initial begin
    #2;
    check_all_zero("reset0");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_ready0", W'(o_pix_ready), W'(0));

    // full frame, valid every cycle
    send_frame(0, -1, -1, 16);
    // reset mid-stream: outputs clear at once, ready stays low until a new start
    send_frame(0, -1, -1, 6);
    i_pix_valid = 1'b1;
    #2 RST = 1'b0;
    #1 check_all_zero("reset_mid");
    @(negedge CLK);
    RST = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge CLK);
      check("reset_ready_low", W'(o_pix_ready), W'(0));
    end
    i_pix_valid = 1'b0;
    // random gaps in i_pix_valid
    send_frame(2, -1, -1, 16);
    // abort at pixel 9, then a clean frame
    send_frame(0, 9, -1, 16);
    send_frame(0, -1, -1, 16);
    // start pulse in the middle of a frame is ignored
    send_frame(0, -1, 7, 16);
    // two back-to-back frames
    send_frame(1, -1, -1, 16);
    send_frame(0, -1, -1, 16);

    repeat (3) @(negedge CLK);
    check("final_queue_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
